// File: rtl/ex_pkg.sv
// Shared op encodings, FSM states and operand-sign helpers for the execute-stage mul/div unit.
package ex_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic f3_signed_a(input logic [2:0] f3);
    return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
  endfunction

  // MULHSU treats rs2 as unsigned, so only these four look at its sign.
  function automatic logic f3_signed_b(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Request/response channel between the execute stage and the mul/div unit.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic [4:0]      req_rd;
  logic [XLEN-1:0] req_pc;
  logic            flush;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic [4:0]      resp_rd;
  logic [XLEN-1:0] resp_pc;
  logic            busy;

  modport master (
    output req_valid, req_funct3, req_rs1, req_rs2, req_rd, req_pc, flush, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_pc, busy
  );

  modport slave (
    input  req_valid, req_funct3, req_rs1, req_rs2, req_rd, req_pc, flush, resp_ready,
    output req_ready, resp_valid, resp_data, resp_rd, resp_pc, busy
  );
endinterface

// File: rtl/ex_mul_step.sv
// One shift-add multiply step: adds mcand x low MUL_BITS of acc into the upper half, then shifts right.
module ex_mul_step #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 4
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   mcand,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN+MUL_BITS-1:0] pp;
  logic [XLEN+MUL_BITS-1:0] sum;

  always_comb begin
    pp       = {{MUL_BITS{1'b0}}, mcand} * {{XLEN{1'b0}}, acc[MUL_BITS-1:0]};
    sum      = pp + {{MUL_BITS{1'b0}}, acc[2*XLEN-1:XLEN]};
    acc_next = {sum, acc[XLEN-1:MUL_BITS]};
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply-divide unit with valid/ready request and response channels.
// Define EX_DIV_EN to build the divider; otherwise divide/remainder ops return 0 in one cycle.
//
// state  | meaning
// S_IDLE | waiting for a request, req_ready high
// S_MUL  | shift-add multiply, MUL_BITS per cycle
// S_DIV  | restoring divide, one bit per cycle
// S_DONE | result held on resp_* until resp_ready
module ex_muldiv_unit
  import ex_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 4
) (
  input  logic            clk_I,
  input  logic            rst_n,
  ex_muldiv_unit_if.slave io
);

  localparam int N_MUL = XLEN / MUL_BITS;
  localparam int CNT_W = $clog2(XLEN);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        f3_q;
  logic              neg_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   mcand_q;
  logic [XLEN-1:0]   data_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   pc_q;

  logic              is_idle, accept, last_mul;
  logic              sa, sb, fast;
  logic [XLEN-1:0]   a_mag, b_mag, fast_data, mul_res;
  logic [2*XLEN-1:0] step_acc, acc_nx, prod;
  logic [XLEN-1:0]   step_mcand;

  assign is_idle  = (state_q == S_IDLE);
  assign accept   = is_idle && io.req_valid && !io.flush;
  assign last_mul = (state_q == S_MUL) && (cnt_q == CNT_W'(N_MUL - 1));

  always_comb begin
    sa    = io.req_rs1[XLEN-1] && f3_signed_a(io.req_funct3);
    sb    = io.req_rs2[XLEN-1] && f3_signed_b(io.req_funct3);
    a_mag = sa ? -io.req_rs1 : io.req_rs1;
    b_mag = sb ? -io.req_rs2 : io.req_rs2;
  end

  // The acceptance edge already performs the first iteration on the incoming magnitudes.
  assign step_acc   = is_idle ? {{XLEN{1'b0}}, b_mag} : acc_q;
  assign step_mcand = is_idle ? a_mag : mcand_q;

  ex_mul_step #(
    .XLEN     (XLEN),
    .MUL_BITS (MUL_BITS)
  ) u_mul_step (
    .acc      (step_acc),
    .mcand    (step_mcand),
    .acc_next (acc_nx)
  );

  always_comb begin
    prod    = neg_q ? -acc_nx : acc_nx;
    mul_res = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

`ifdef EX_DIV_EN
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic            rneg_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [XLEN-1:0] r_in, q_in, d_in, r_nx, q_nx, div_res;
  logic [XLEN:0]   r_sh, diff;
  logic            div_zero, ovf, last_div;

  assign last_div = (state_q == S_DIV) && (cnt_q == CNT_W'(XLEN - 1));

  always_comb begin
    r_in    = is_idle ? '0 : rem_q;
    q_in    = is_idle ? a_mag : quo_q;
    d_in    = is_idle ? b_mag : dvs_q;
    r_sh    = {r_in, q_in[XLEN-1]};
    diff    = r_sh - {1'b0, d_in};
    r_nx    = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
    q_nx    = {q_in[XLEN-2:0], ~diff[XLEN]};
    div_res = f3_q[1] ? (rneg_q ? -r_nx : r_nx) : (neg_q ? -q_nx : q_nx);
  end

  always_comb begin
    div_zero  = (io.req_rs2 == '0);
    ovf       = !io.req_funct3[0] && (io.req_rs1 == MOST_NEG) && (io.req_rs2 == '1);
    fast      = div_zero || ovf;
    if (io.req_funct3[1]) fast_data = div_zero ? io.req_rs1 : '0;
    else                  fast_data = div_zero ? '1 : io.req_rs1;
  end
`else
  always_comb begin
    fast      = 1'b1;
    fast_data = '0;
  end
`endif

  always_ff @(posedge clk_I or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    io.req_ready  = 1'b0;
    io.resp_valid = 1'b0;
    io.busy       = 1'b1;
    case (state_q)
      S_IDLE: begin
        io.req_ready = 1'b1;
        io.busy      = 1'b0;
        if (accept) begin
          if (!io.req_funct3[2]) state_d = S_MUL;
          else if (fast)         state_d = S_DONE;
`ifdef EX_DIV_EN
          else                   state_d = S_DIV;
`endif
        end
      end
      S_MUL:  if (last_mul) state_d = S_DONE;
`ifdef EX_DIV_EN
      S_DIV:  if (last_div) state_d = S_DONE;
`endif
      S_DONE: begin
        io.resp_valid = 1'b1;
        if (io.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (io.flush) state_d = S_IDLE;
  end

  // A flushed op leaves every datapath register untouched, so no stale result leaks out.
  always_ff @(posedge clk_I or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      pc_q    <= '0;
`ifdef EX_DIV_EN
      rneg_q  <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
`endif
    end else if (!io.flush) begin
      if (accept) begin
        f3_q    <= io.req_funct3;
        rd_q    <= io.req_rd;
        pc_q    <= io.req_pc;
        neg_q   <= sa ^ sb;
        cnt_q   <= CNT_W'(1);
        acc_q   <= acc_nx;
        mcand_q <= a_mag;
`ifdef EX_DIV_EN
        rneg_q  <= sa;
        rem_q   <= r_nx;
        quo_q   <= q_nx;
        dvs_q   <= b_mag;
`endif
        if (io.req_funct3[2] && fast) data_q <= fast_data;
      end else if (state_q == S_MUL) begin
        acc_q <= acc_nx;
        if (last_mul) begin
          data_q <= mul_res;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
`ifdef EX_DIV_EN
      else if (state_q == S_DIV) begin
        rem_q <= r_nx;
        quo_q <= q_nx;
        if (last_div) begin
          data_q <= div_res;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
`endif
    end
  end

  assign io.resp_data = data_q;
  assign io.resp_rd   = rd_q;
  assign io.resp_pc   = pc_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit at XLEN=32, MUL_BITS=4.
module tb_ex_muldiv_unit;
  import ex_pkg::*;

  localparam int XLEN = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   op_id    = 0;

  ex_muldiv_unit_if #(.XLEN(XLEN)) bus ();

  ex_muldiv_unit #(
    .XLEN     (XLEN),
    .MUL_BITS (4)
  ) dut (
    .clk_I (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] pc);
    bus.req_funct3 = f3;
    bus.req_rs1    = a;
    bus.req_rs2    = b;
    bus.req_rd     = rd;
    bus.req_pc     = pc;
    bus.req_valid  = 1'b1;
    tick();
    bus.req_valid  = 1'b0;
  endtask

  // lat counts edges from the acceptance edge up to the one that raises resp_valid.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_data, input int exp_lat);
    int          lat;
    logic [4:0]  rd;
    logic [31:0] pc;
    op_id++;
    rd = 5'(op_id);
    pc = 32'h0000_1000 + 32'(op_id * 4);
    check({tag, "_ready"}, bus.req_ready, 1);
    issue(f3, a, b, rd, pc);
    wait_resp(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, bus.resp_data, exp_data);
    check({tag, "_rd"}, bus.resp_rd, rd);
    check({tag, "_pc"}, bus.resp_pc, pc);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check({tag, "_idle"}, {bus.resp_valid, bus.req_ready}, 2'b01);
  endtask

  initial begin
    int lat;
    int seen;

    bus.req_valid  = 1'b0;
    bus.req_funct3 = '0;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.req_rd     = '0;
    bus.req_pc     = '0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_data", bus.resp_data, 0);
    check("rst_resp_rd", bus.resp_rd, 0);
    check("rst_resp_pc", bus.resp_pc, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_req_ready", bus.req_ready, 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    run_op("mul_neg", F3_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 8);
    run_op("mul_pos", F3_MUL, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 8);
    run_op("mulh_min", F3_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 8);
    run_op("mulh_m1", F3_MULH, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 8);
    run_op("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 8);
    run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8);

`ifdef EX_DIV_EN
    run_op("div_neg", F3_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32);
    run_op("rem_neg", F3_REM, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32);
    run_op("divu", F3_DIVU, 32'd100, 32'd7, 32'd14, 32);
    run_op("remu", F3_REMU, 32'd100, 32'd7, 32'd2, 32);
    run_op("divu_big", F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32);
    run_op("divu_zero", F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_zero", F3_REM, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
`else
    run_op("div_off", F3_DIV, 32'd10, 32'd2, 32'd0, 1);
    run_op("divu_off", F3_DIVU, 32'd5, 32'd0, 32'd0, 1);
    run_op("remu_off", F3_REMU, 32'd7, 32'd3, 32'd0, 1);
`endif

    // Backpressure: result must hold while a stray request is ignored.
    issue(F3_MUL, 32'd3, 32'd5, 5'd9, 32'h0000_0100);
    wait_resp(lat);
    check("bp_lat", lat, 8);
    bus.req_valid = 1'b1;
    bus.req_rs1   = 32'd77;
    bus.req_rd    = 5'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", {bus.resp_valid, bus.req_ready, bus.busy}, 3'b101);
      check("bp_data", bus.resp_data, 32'd15);
      check("bp_rd", bus.resp_rd, 5'd9);
      check("bp_pc", bus.resp_pc, 32'h0000_0100);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check("bp_release", {bus.resp_valid, bus.req_ready}, 2'b01);
    run_op("bp_next", F3_MUL, 32'd2, 32'd3, 32'd6, 8);

    // Flush in the third cycle of a multiply.
    issue(F3_MUL, 32'd9, 32'd9, 5'd1, 32'h0000_0200);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_mul", {bus.resp_valid, bus.req_ready, bus.busy}, 3'b010);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.resp_valid === 1'b1) seen = 1;
    end
    check("flush_mul_quiet", seen, 0);

`ifdef EX_DIV_EN
    issue(F3_DIV, 32'd100, 32'd3, 5'd2, 32'h0000_0300);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_div", {bus.resp_valid, bus.req_ready, bus.busy}, 3'b010);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.resp_valid === 1'b1) seen = 1;
    end
    check("flush_div_quiet", seen, 0);
`endif

    // Flush wins over a same-cycle request.
    bus.req_funct3 = F3_MUL;
    bus.req_rs1    = 32'd4;
    bus.req_rs2    = 32'd4;
    bus.req_valid  = 1'b1;
    bus.flush      = 1'b1;
    tick();
    bus.req_valid  = 1'b0;
    bus.flush      = 1'b0;
    check("flush_req", {bus.busy, bus.req_ready}, 2'b01);

    // Flush drops a pending result in DONE.
    issue(F3_MUL, 32'd4, 32'd4, 5'd21, 32'h0000_0400);
    wait_resp(lat);
    check("flush_done_lat", lat, 8);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_done", {bus.resp_valid, bus.req_ready}, 2'b01);

    // Asynchronous reset in the middle of a multiply.
    issue(F3_MUL, 32'd6, 32'd7, 5'd17, 32'h0000_0500);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_resp_valid", bus.resp_valid, 0);
    check("arst_resp_data", bus.resp_data, 0);
    check("arst_resp_rd", bus.resp_rd, 0);
    check("arst_resp_pc", bus.resp_pc, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_req_ready", bus.req_ready, 1);
    #2 rst_n = 1'b1;
    tick();
    run_op("post_rst", F3_MUL, 32'd6, 32'd7, 32'd42, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Multi-cycle RV32M/RV64M multiply–divide unit for the execute stage. It replaces the single-cycle, low-word-only `RF_rdata1 * RF_rdata2` product. Operands arrive over a valid/ready request channel and results leave over a valid/ready response channel, so the pipeline no longer needs clock gating to stall. It supports all eight M-extension ops, with configurable width and multiply throughput, and a divider that can be compiled out.

## Interface
- XLEN, 32: datapath width; 32 or 64.
- MUL_BITS, 4: multiplier bits retired per cycle; one of 1, 2, 4, 8; must divide XLEN.
- clk_I  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_funct3  in  3  M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req_rs1, req_rs2  in  XLEN  operands.
- req_rd  in  5  destination register.
- req_pc  in  XLEN  instruction PC.
- flush  in  1  abort in-flight op (branch redirect).
- resp_valid  out  1  result present.
- resp_ready  in  1  consumer takes result.
- resp_data  out  XLEN  result.
- resp_rd  out  5  echoed req_rd.
- resp_pc  out  XLEN  echoed req_pc.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, MUL, DIV, DONE. Reset enters IDLE.
- IDLE accept (req_valid & req_ready & ~flush) latches rd, pc, funct3, and operand magnitudes plus result sign.
  - funct3[2]=0 → MUL.
  - funct3[2]=1 with a fast-path condition → DONE.
  - funct3[2]=1 otherwise → DIV.
- MUL: unsigned shift-add, MUL_BITS per edge, 2·XLEN accumulator.
  - Runs N_MUL = XLEN/MUL_BITS iterations.
  - Signed ops multiply magnitudes and negate the 2·XLEN product when the signs differ.
  - MUL returns low half; MULH, MULHSU, MULHU return high half.
  - MULHSU treats rs2 as unsigned.
- DIV: restoring divide on magnitudes, 1 bit per edge, XLEN iterations.
  - Quotient sign = sign(rs1) ^ sign(rs2).
  - Remainder sign = sign(rs1).
- Fast paths (1-cycle ops):
  - Divisor 0: quotient all-ones; remainder = rs1.
  - Signed overflow (rs1 = most-negative, rs2 = -1): quotient = rs1; remainder = 0.
- The final iteration writes the sign-corrected result into resp_data and moves to DONE.
- DONE: resp_valid=1. Outputs hold stable until resp_ready. On handshake → IDLE and resp_valid drops.
- flush: from any state → IDLE on the next edge and no response is produced. flush beats req_valid in the same cycle, so the request is not accepted. In DONE, flush drops the pending result.
- No overlap: a new request can be accepted only the cycle after a response handshake.

## Timing
- Request accepted at edge T (acceptance cycle = cycle T).
- MUL ops: resp_valid is visible in cycle T+N_MUL.
- DIV/REM ops: resp_valid is visible in cycle T+XLEN.
- Fast-path ops: resp_valid is visible in cycle T+1.
- A response handshake at edge R makes req_ready high in cycle R+1.
- Reset values: resp_valid 0, resp_data 0, resp_rd 0, resp_pc 0, busy 0, req_ready 1.
- rst_n low takes effect immediately, mid-operation included; iteration counters clear.

## Configuration
- EX_DIV_EN defined: full DIV/DIVU/REM/REMU as above.
- EX_DIV_EN undefined:
  - DIV state and divider datapath are removed.
  - funct3[2]=1 requests take the 1-cycle path with resp_data = 0.
  - MUL behaviour is unchanged.

## Structure
- Package ex_pkg: funct3 localparams (F3_MUL … F3_REMU) and the state enum (S_IDLE, S_MUL, S_DIV, S_DONE).
- Sub-module ex_mul_step: combinational MUL_BITS-wide partial-product add of multiplicand × multiplier slice into the accumulator.
- The FSM, divider and sign fix-up live in the top module.

## Test plan
- XLEN=32, MUL_BITS=4: MUL 7 × 0xFFFFFFFD → resp_data 0xFFFFFFEB, resp_valid 8 cycles after acceptance, resp_rd/resp_pc echo inputs.
- High-half products:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide: DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; each result 32 cycles after acceptance.
- Fast paths (each resp_valid 1 cycle after acceptance):
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- Backpressure: resp_ready low for 5 cycles in DONE → resp_data/rd/pc stable, req_ready 0; resp_ready high → IDLE next cycle, next request accepted.
- Abort and reset:
  - flush in the 3rd DIV cycle → no resp_valid, req_ready=1 next cycle.
  - rst_n low mid-MUL → all outputs at reset values immediately.
  - EX_DIV_EN undefined build: DIV 10/2 → resp_data 0 after 1 cycle.
